// File: rtl/vga_fb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fb_arbiter_if
//  Description : Bundles the three buses around the frame-buffer arbiter:
//                the CPU Wishbone slave port, the scan-out read port and
//                the single-port RAM port.
//                slave  - arbiter view (drives wb_dat_o/wb_ack_o, vga_*
//                         outputs and the mem_* request lines)
//                master - environment view (CPU, scan-out engine, RAM)
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_fb_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 12
);
  // Wishbone slave port
  logic          wb_stb_i;
  logic          wb_cyc_i;
  logic          wb_we_i;
  logic [31:0]   wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  // Scan-out read port
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_data;
  logic          vga_valid;
  // Single-port RAM
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o,
    input  vga_req, vga_addr,
    output vga_data, vga_valid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o,
    output vga_req, vga_addr,
    input  vga_data, vga_valid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fb_arbiter
//  Description : Shares one single-port frame-buffer RAM between the VGA
//                scan-out (absolute priority) and a Wishbone CPU port.
//                Ports: clk, reset (async, active-high), bus (slave modport
//                of vga_fb_arbiter_if: Wishbone, scan-out and RAM signals).
//                Register space (wb_adr_i[17]=1), offset 0: 16-bit
//                saturating count of cycles a CPU access was stalled by
//                scan-out; any write there clears it.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
  parameter int AW       = 15,
  parameter int DW       = 12,
  parameter int FB_WORDS = 19200
) (
  input  wire logic       clk,
  input  wire logic       reset,
  vga_fb_arbiter_if.slave bus
);

  localparam logic [1:0]  c_st_idle  = 2'd0;
  localparam logic [1:0]  c_st_wait  = 2'd1;
  localparam logic [1:0]  c_st_rd    = 2'd2;
  localparam logic [1:0]  c_st_ack   = 2'd3;
  // One extra bit so FB_WORDS == 2**AW is still representable.
  localparam logic [AW:0] c_fb_words = FB_WORDS[AW:0];

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [31:0]   r_wb_dat;
  logic [15:0]   r_stall;
  logic          r_vga_valid;

  logic [AW-1:0] w_word_addr;
  logic          w_req;
  logic          w_reg_sel;
  logic          w_reg_off0;
  logic          w_fb_hit;
  logic          w_stall_clr;
  logic [31:0]   w_bypass_rdata;
  logic          w_cpu_grant;
  logic          w_stall;
  logic          w_ack;
  logic          w_unused;

  assign w_word_addr = bus.wb_adr_i[AW+1:2];
  assign w_req       = bus.wb_stb_i & bus.wb_cyc_i;
  assign w_reg_sel   = bus.wb_adr_i[17];
  assign w_reg_off0  = (bus.wb_adr_i[16:2] == 15'd0);
  assign w_fb_hit    = ~w_reg_sel & ({1'b0, w_word_addr} < c_fb_words);
  assign w_stall_clr = (r_state == c_st_idle) & w_req & w_reg_sel & w_reg_off0 & bus.wb_we_i;

  // Accesses that never touch RAM are answered straight from IDLE; an
  // out-of-range frame-buffer read yields zero.
  assign w_bypass_rdata = (w_reg_sel & w_reg_off0 & ~bus.wb_we_i) ? {16'h0000, r_stall} : 32'h0;

  assign w_unused = &{1'b0, bus.wb_adr_i[31:18], bus.wb_adr_i[1:0], bus.wb_dat_i[31:DW]};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_st_idle;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (w_req) w_next_state = w_fb_hit ? c_st_wait : c_st_ack;
      c_st_wait: begin
        if (!bus.wb_cyc_i)     w_next_state = c_st_idle;
        else if (!bus.vga_req) w_next_state = bus.wb_we_i ? c_st_ack : c_st_rd;
      end
      c_st_rd:   w_next_state = c_st_ack;
      c_st_ack:  w_next_state = c_st_idle;
      default:   w_next_state = c_st_idle;
    endcase
  end

  // Output decode
  always_comb begin
    w_cpu_grant = 1'b0;
    w_stall     = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      c_st_wait: begin
        w_cpu_grant = bus.wb_cyc_i & ~bus.vga_req;
        w_stall     = bus.wb_cyc_i &  bus.vga_req;
      end
      c_st_ack: w_ack = 1'b1;
      default: ;
    endcase
  end

  // Scan-out owns the RAM whenever it asks; the CPU only gets leftover cycles.
  assign bus.mem_en    = bus.vga_req | w_cpu_grant;
  assign bus.mem_we    = ~bus.vga_req & w_cpu_grant & bus.wb_we_i;
  assign bus.mem_addr  = bus.vga_req ? bus.vga_addr : w_word_addr;
  assign bus.mem_wdata = bus.wb_dat_i[DW-1:0];

  assign bus.wb_ack_o  = w_ack;
  assign bus.wb_dat_o  = r_wb_dat;
  assign bus.vga_valid = r_vga_valid;
  assign bus.vga_data  = bus.mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_dat    <= 32'h0;
      r_stall     <= 16'h0;
      r_vga_valid <= 1'b0;
    end else begin
      r_vga_valid <= bus.vga_req;

      if ((r_state == c_st_idle) && w_req && !w_fb_hit)
        r_wb_dat <= w_bypass_rdata;
      else if (r_state == c_st_rd)
        r_wb_dat <= {{(32-DW){1'b0}}, bus.mem_rdata};

      // Clear wins over a simultaneous increment.
      if (w_stall_clr)
        r_stall <= 16'h0;
      else if (w_stall && (r_stall != 16'hFFFF))
        r_stall <= r_stall + 16'd1;
    end
  end

endmodule
`default_nettype wire
